// File: rtl/nco_i2c_master.sv
`default_nettype none
// ============================================================================
// nco_i2c_master : write-only I2C master that sends address, control and data bytes to the NCO slave
// Revision 1.0
// ============================================================================
module nco_i2c_master #(
    parameter logic [6:0] ADDRESS = 7'b1101010,
    parameter int         CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic        enable,
    input  logic [1:0]  wave,
    input  logic [63:0] frequency,
    input  logic [15:0] duty_cycle,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic        scl,
    inout  wire         sda
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [1:0]       q, q_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [3:0]       byte_cnt, byte_n;
    logic [DIV_W-1:0] div;
    logic             done_n, nack_n, scl_n, sda_low, sda_low_n;
    logic             accept, q_tick;
    logic [1:0]       cmd_l, wave_l;
    logic             en_l;
    logic [63:0]      freq_l;
    logic [15:0]      duty_l;
    logic [3:0]       last_byte;
    logic [2:0]       data_idx;
    logic [7:0]       tx_byte;

    // A start coinciding with the done pulse is dropped so frames never overlap.
    assign accept    = (state == S_IDLE) && start && !done;
    assign q_tick    = (state != S_IDLE) && (div == DIV_W'(CLK_DIV - 1));
    assign busy      = (state != S_IDLE);
    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign last_byte = (cmd_l == 2'b01) ? 4'd9 : (cmd_l == 2'b10) ? 4'd3 : 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            div      <= '0;
            scl      <= 1'b1;
            sda_low  <= 1'b0;
            done     <= 1'b0;
            nack_err <= 1'b0;
            cmd_l    <= '0;
            en_l     <= 1'b0;
            wave_l   <= '0;
            freq_l   <= '0;
            duty_l   <= '0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            scl      <= scl_n;
            sda_low  <= sda_low_n;
            done     <= done_n;
            nack_err <= nack_n;
            if (state == S_IDLE || q_tick)
                div <= '0;
            else
                div <= div + DIV_W'(1);
            if (accept) begin
                cmd_l  <= cmd;
                en_l   <= enable;
                wave_l <= wave;
                freq_l <= frequency;
                duty_l <= duty_cycle;
            end
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        done_n  = 1'b0;
        nack_n  = nack_err;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                    q_n     = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                    nack_n  = 1'b0;
                end
            end
            S_START: begin
                if (q_tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd2) begin
                        state_n = S_BIT;
                        q_n     = '0;
                    end
                end
            end
            S_BIT: begin
                if (q_tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (q_tick) begin
                    q_n = q + 2'd1;
                    // Last clk of Q2 sits mid-way through the SCL high phase.
                    if (q == 2'd2 && sda)
                        nack_n = 1'b1;
                    if (q == 2'd3) begin
                        if (nack_err || byte_cnt == last_byte) begin
                            state_n = S_STOP;
                        end else begin
                            state_n = S_BIT;
                            byte_n  = byte_cnt + 4'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (q_tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        data_idx = byte_n[2:0] - 3'd2;
        if (byte_n == 4'd0)
            tx_byte = {ADDRESS, 1'b0};
        else if (byte_n == 4'd1)
            tx_byte = {3'b000, cmd_l[1], cmd_l[0], wave_l, en_l};
        else if (cmd_l == 2'b10)
            tx_byte = data_idx[0] ? duty_l[15:8] : duty_l[7:0];
        else
            tx_byte = freq_l[{data_idx, 3'b000} +: 8];
    end

    // Line levels are decoded from the next state so SCL/SDA come straight from flops.
    always_comb begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        case (state_n)
            S_START: begin
                scl_n     = (q_n != 2'd2);
                sda_low_n = (q_n != 2'd0);
            end
            S_BIT: begin
                scl_n     = q_n[1];
                sda_low_n = ~tx_byte[3'd7 - bit_n];
            end
            S_ACK:  scl_n = q_n[1];
            S_STOP: begin
                scl_n     = (q_n != 2'd0);
                sda_low_n = ~q_n[1];
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_nco_i2c_master.sv
`default_nettype none
// ============================================================================
// tb_nco_i2c_master : randomized bench with a behavioural I2C slave and frame model
// Revision 1.0
// ============================================================================
module tb_nco_i2c_master;
    localparam int         D    = 4;
    localparam logic [6:0] ADDR = 7'b1101010;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, enable = 1'b0;
    logic [1:0]  cmd = '0, wave = '0;
    logic [63:0] frequency = '0;
    logic [15:0] duty_cycle = '0;
    wire         busy, done, nack_err, scl, sda_line;
    logic        slave_low = 1'b0;

    assign sda_line = slave_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    nco_i2c_master #(.ADDRESS(ADDR), .CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .enable(enable), .wave(wave),
        .frequency(frequency), .duty_cycle(duty_cycle), .busy(busy), .done(done),
        .nack_err(nack_err), .scl(scl), .sda(sda_line)
    );

    always #5 clk = ~clk;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] rx_q[$], exp_q[$];
    int         nack_at = -1, rises = 0, starts = 0, stops = 0;
    int         cyc_to_done, done_pulses;
    logic       busy_at0;

    // Behavioural slave: a bit is committed on the SCL falling edge after its rising edge.
    logic prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, got_rise = 1'b0, pend_bit = 1'b0;
    int   bitcnt = 0;
    logic [7:0] shreg = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0; got_rise = 1'b0; bitcnt = 0; slave_low = 1'b0;
        end else if (prev_scl && scl && prev_sda && !sda_line) begin
            starts++; in_frame = 1'b1; bitcnt = 0; got_rise = 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda_line) begin
            stops++; in_frame = 1'b0;
        end else if (in_frame && !prev_scl && scl) begin
            got_rise = 1'b1; pend_bit = sda_line;
        end else if (in_frame && prev_scl && !scl && got_rise) begin
            got_rise = 1'b0; rises++;
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], pend_bit}; bitcnt++;
                if (bitcnt == 8) begin
                    rx_q.push_back(shreg);
                    slave_low = ((rx_q.size() - 1) != nack_at);
                end
            end else begin
                slave_low = 1'b0; bitcnt = 0;
            end
        end
        prev_scl = scl; prev_sda = sda_line;
    end

    task automatic build_expected(input logic [1:0] c, input logic en, input logic [1:0] w,
                                  input logic [63:0] f, input logic [15:0] d);
        exp_q.delete();
        exp_q.push_back({ADDR, 1'b0});
        exp_q.push_back({3'b000, (c == 2'b10) || (c == 2'b11), (c == 2'b01) || (c == 2'b11), w, en});
        if (c == 2'b01) for (int i = 0; i < 8; i++) exp_q.push_back(f[8*i +: 8]);
        else if (c == 2'b10) begin exp_q.push_back(d[7:0]); exp_q.push_back(d[15:8]); end
    endtask

    task automatic clear_log(input int nack_idx);
        rx_q.delete(); rises = 0; starts = 0; stops = 0; nack_at = nack_idx;
    endtask

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic launch(input logic [1:0] c, input logic en, input logic [1:0] w,
                          input logic [63:0] f, input logic [15:0] d, input int nack_idx);
        clear_log(nack_idx);
        cmd = c; enable = en; wave = w; frequency = f; duty_cycle = d;
        build_expected(c, en, w, f, d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_frame(input int extra_start, input bit scramble, input bit stop_at_done);
        int cyc = 0;
        cyc_to_done = -1; done_pulses = 0; busy_at0 = busy;
        if (scramble) begin
            cmd = 2'($urandom); enable = 1'($urandom); wave = 2'($urandom);
            frequency = {$urandom, $urandom}; duty_cycle = 16'($urandom);
        end
        while (cyc < 400 * D) begin
            start = (cyc == extra_start);
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                done_pulses++;
                if (cyc_to_done < 0) cyc_to_done = cyc;
                if (stop_at_done) break;
            end
            if (cyc_to_done >= 0 && cyc >= cyc_to_done + 2 * D) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_checks++; if (sda_line !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda_line); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (nack_err !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b want 0", nack_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_control_only();
        launch(2'b00, 1'b1, 2'd2, 64'h0, 16'h0, -1);
        finish_frame(-1, 1'b0, 1'b0);
        n_checks++; if (busy_at0 !== 1'b1) begin n_fail++; $display("FAIL ctl_busy_start: got %b want 1", busy_at0); end
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ctl_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ctl_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL ctl_done_count: got %0d want 1", done_pulses); end
        n_checks++;
        if (cyc_to_done < 79 * D - 1 || cyc_to_done > 79 * D + 1) begin n_fail++; $display("FAIL ctl_latency: got %0d want %0d", cyc_to_done, 79 * D); end
        n_checks++; if (nack_err !== 1'b0) begin n_fail++; $display("FAIL ctl_nack: got %b want 0", nack_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ctl_busy_after: got %b want 0", busy); end
        n_checks++; if (stops != 1) begin n_fail++; $display("FAIL ctl_stops: got %0d want 1", stops); end
    endtask

    task automatic test_freq();
        launch(2'b01, 1'b0, 2'd0, 64'h0123456789ABCDEF, 16'h0, -1);
        finish_frame(-1, 1'b1, 1'b0);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL freq_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL freq_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (rises != 90) begin n_fail++; $display("FAIL freq_scl_rises: got %0d want 90", rises); end
        n_checks++; if (starts != 1 || stops != 1) begin n_fail++; $display("FAIL freq_start_stop: got %0d/%0d want 1/1", starts, stops); end
        n_checks++;
        if (cyc_to_done < 367 * D - 1 || cyc_to_done > 367 * D + 1) begin n_fail++; $display("FAIL freq_latency: got %0d want %0d", cyc_to_done, 367 * D); end
    endtask

    task automatic test_duty();
        logic [15:0] duty_seen;
        launch(2'b10, 1'($urandom), 2'($urandom), {$urandom, $urandom}, 16'h8000, -1);
        finish_frame(-1, 1'b1, 1'b0);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL duty_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL duty_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        duty_seen = (rx_q.size() == 4) ? {rx_q[3], rx_q[2]} : 16'h0;
        n_checks++; if (duty_seen !== 16'h8000) begin n_fail++; $display("FAIL duty_slave_value: got %h want 8000", duty_seen); end
        n_checks++;
        if (cyc_to_done < 151 * D - 1 || cyc_to_done > 151 * D + 1) begin n_fail++; $display("FAIL duty_latency: got %0d want %0d", cyc_to_done, 151 * D); end
    endtask

    task automatic test_nack();
        launch(2'b01, 1'b1, 2'd1, {$urandom, $urandom}, 16'h0, 0);
        finish_frame(-1, 1'b0, 1'b0);
        n_checks++; if (nack_err !== 1'b1) begin n_fail++; $display("FAIL nack_flag: got %b want 1", nack_err); end
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL nack_nbytes: got %0d want 1", rx_q.size()); end
        n_checks++; if (rises != 9) begin n_fail++; $display("FAIL nack_scl_rises: got %0d want 9", rises); end
        n_checks++; if (stops != 1 || done_pulses != 1) begin n_fail++; $display("FAIL nack_stop_done: got %0d/%0d want 1/1", stops, done_pulses); end
        n_checks++;
        if (cyc_to_done < 43 * D - 1 || cyc_to_done > 43 * D + 1) begin n_fail++; $display("FAIL nack_latency: got %0d want %0d", cyc_to_done, 43 * D); end
        launch(2'b00, 1'b0, 2'd3, 64'h0, 16'h0, -1);
        n_checks++; if (nack_err !== 1'b0) begin n_fail++; $display("FAIL nack_cleared: got %b want 0", nack_err); end
        finish_frame(-1, 1'b0, 1'b0);
        n_checks++; if (nack_err !== 1'b0 || rx_q.size() != 2) begin n_fail++; $display("FAIL nack_recovery: got nack=%b n=%0d want 0/2", nack_err, rx_q.size()); end
    endtask

    task automatic test_busy_ignore();
        launch(2'b01, 1'b1, 2'($urandom), {$urandom, $urandom}, 16'($urandom), -1);
        finish_frame(80 * D + 1, 1'b1, 1'b0);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ign_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", done_pulses); end
        n_checks++;
        if (cyc_to_done < 367 * D - 1 || cyc_to_done > 367 * D + 1) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", cyc_to_done, 367 * D); end
    endtask

    task automatic test_back_to_back();
        launch(2'b00, 1'b1, 2'd0, 64'h0, 16'h0, -1);
        finish_frame(-1, 1'b0, 1'b1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        clear_log(-1);
        cmd = 2'b10; enable = 1'b0; wave = 2'd1; duty_cycle = 16'($urandom);
        build_expected(cmd, enable, wave, frequency, duty_cycle);
        start = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done: got busy=%b want 0", busy); end
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_after_done: got busy=%b want 1", busy); end
        finish_frame(-1, 1'b1, 1'b0);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++;
        if (cyc_to_done < 151 * D - 1 || cyc_to_done > 151 * D + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", cyc_to_done, 151 * D); end
    endtask

    task automatic test_reset_midframe();
        int late_done = 0;
        launch(2'b10, 1'b1, 2'd2, 64'h0, 16'($urandom), -1);
        // Quarter 53 is Q2 of the fourth bit of the control byte.
        for (int i = 0; i < 53 * D + 1; i++) @(negedge clk);
        n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_pre_scl: got %b want 1", scl); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_mid_scl: got %b want 1", scl); end
        n_checks++; if (sda_line !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sda: got %b want 1", sda_line); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        repeat (3) begin @(negedge clk); if (done !== 1'b0) late_done++; end
        n_checks++; if (late_done != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses want 0", late_done); end
        rst_n = 1'b1;
        @(negedge clk);
        launch(2'b01, 1'($urandom), 2'($urandom), {$urandom, $urandom}, 16'h0, -1);
        finish_frame(-1, 1'b1, 1'b0);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_after_nbytes: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_after_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL rst_after_done: got %0d want 1", done_pulses); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [1:0] c;
            int nack_idx, nsent, exp_cyc;
            c = 2'($urandom);
            launch(c, 1'($urandom), 2'($urandom), {$urandom, $urandom}, 16'($urandom), -1);
            nack_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            nack_at = nack_idx;
            nsent = (nack_idx >= 0) ? nack_idx + 1 : exp_q.size();
            exp_cyc = (7 + 36 * nsent) * D;
            finish_frame(-1, 1'b1, 1'b0);
            n_checks++;
            if (rx_q.size() != nsent) begin n_fail++; $display("FAIL rnd%0d_nbytes: got %0d want %0d", n, rx_q.size(), nsent); end
            else foreach (rx_q[i]) begin
                n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", n, i, rx_q[i], exp_q[i]); end
            end
            n_checks++;
            if (cyc_to_done < exp_cyc - 1 || cyc_to_done > exp_cyc + 1) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, cyc_to_done, exp_cyc); end
            n_checks++;
            if (nack_err !== (nack_idx >= 0)) begin n_fail++; $display("FAIL rnd%0d_nack: got %b want %b", n, nack_err, nack_idx >= 0); end
            n_checks++; if (rises != 9 * nsent) begin n_fail++; $display("FAIL rnd%0d_scl_rises: got %0d want %0d", n, rises, 9 * nsent); end
            n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL rnd%0d_done_count: got %0d want 1", n, done_pulses); end
        end
    endtask

    initial begin
        test_reset();
        test_control_only();
        test_freq();
        test_duty();
        test_nack();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
